// File: rtl/bit_serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder slice.
package bit_serial_adder_pkg;
  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {IDLE, ADD, DONE, LOAD, HOLD} state_e;
endpackage

// File: rtl/bit_serial_adder_if.sv
// Operand/result bundle for bit_serial_adder. The Sub line exists only when SUBTRACT_EN is defined.
interface bit_serial_adder_if
  import bit_serial_adder_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH);
  logic             Run;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
`ifdef SUBTRACT_EN
  logic             Sub;
`endif
  logic [WIDTH-1:0] Sum;
  logic             Ofl;
  logic             Ld_B;
  logic             Busy;

  modport master (
    output Run, A, B,
`ifdef SUBTRACT_EN
    output Sub,
`endif
    input  Sum, Ofl, Ld_B, Busy
  );

  modport slave (
    input  Run, A, B,
`ifdef SUBTRACT_EN
    input  Sub,
`endif
    output Sum, Ofl, Ld_B, Busy
  );
endinterface

// File: rtl/bit_serial_adder_full_adder.sv
// One-bit combinational full adder used as the serial datapath slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one result bit per clock, LSB first, then a registered Ld_B strobe.
// Define SUBTRACT_EN to add the Sub port (A - B computed as A + ~B + 1).
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH) (
  input logic               Clk,
  input logic               Reset,
  bit_serial_adder_if.slave bus
);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, cnt_q, cnt_d;
  logic             carry_q, carry_d, ofl_q, ofl_d;
  logic             ld_b_q, ld_b_d, busy_q, busy_d;
  logic             cin0, fa_s, fa_cout;

`ifdef SUBTRACT_EN
  assign cin0 = bus.Sub;
`else
  assign cin0 = 1'b0;
`endif

  full_adder u_fa (.a(a_q[0]), .b(b_q[0]), .cin(carry_q), .s(fa_s), .cout(fa_cout));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ofl_d   = ofl_q;
    case (state_q)
      IDLE: if (bus.Run) begin
        // B is stored already inverted for subtract, so ADD never looks at Sub again.
        a_d     = bus.A;
        b_d     = cin0 ? ~bus.B : bus.B;
        cnt_d   = '0;
        carry_d = cin0;
        state_d = ADD;
      end
      ADD: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          ofl_d   = carry_q ^ fa_cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = LOAD;
      LOAD:    state_d = HOLD;
      HOLD:    if (!bus.Run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobes follow the next state so they are flop outputs aligned with it.
    ld_b_d = (state_d == LOAD);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ofl_q   <= 1'b0;
      ld_b_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ofl_q   <= ofl_d;
      ld_b_q  <= ld_b_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.Sum  = sum_q;
  assign bus.Ofl  = ofl_q;
  assign bus.Ld_B = ld_b_q;
  assign bus.Busy = busy_q;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed + randomized bench for bit_serial_adder against a signed-arithmetic reference model.
module tb_bit_serial_adder;
  localparam int W = 16;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  bit_serial_adder_if #(.WIDTH(W)) bus ();
  bit_serial_adder #(.WIDTH(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed result, then wrap and range-check.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] s, output logic o);
    int sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    r  = sub ? sa - sb : sa + sb;
    s  = r[W-1:0];
    o  = (r > 32767) || (r < -32768);
  endtask

  task automatic drive_sub(input logic sub);
`ifdef SUBTRACT_EN
    bus.Sub = sub;
`endif
  endtask

  // One Run-pulse operation; capture edge is counted as edge 1, so Ld_B should rise on edge W+2.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input bit scramble);
    logic [W-1:0] es;
    logic         eo;
    int           edges;
    bit           seen;
    model(a, b, sub, es, eo);
    @(negedge Clk);
    bus.A = a; bus.B = b; drive_sub(sub); bus.Run = 1'b1;
    @(posedge Clk); #1;
    bus.Run = 1'b0;
    chk("busy_after_capture", bus.Busy, 1);
    edges = 1;
    seen  = 0;
    while (!seen && edges < 40) begin
      if (scramble) begin
        bus.A = W'($urandom); bus.B = W'($urandom); drive_sub(1'($urandom));
      end
      @(posedge Clk); #1;
      edges++;
      if (edges == W + 1) begin
        chk("done_sum", bus.Sum, es);
        chk("done_ofl", bus.Ofl, eo);
        chk("done_ldb_low", bus.Ld_B, 0);
      end
      if (bus.Ld_B === 1'b1) seen = 1;
    end
    chk("ldb_edge", seen ? edges : 0, W + 2);
    chk("load_sum", bus.Sum, es);
    chk("load_ofl", bus.Ofl, eo);
    @(posedge Clk); #1;
    chk("ldb_one_cycle", bus.Ld_B, 0);
    chk("hold_sum", bus.Sum, es);
    @(posedge Clk); #1;
    chk("idle_busy", bus.Busy, 0);
    chk("idle_ofl", bus.Ofl, eo);
  endtask

  initial begin
    int pulses;
    logic sub;
    bus.Run = 1'b0; bus.A = '0; bus.B = '0; drive_sub(1'b0);
    #1;
    chk("rst_sum", bus.Sum, 0);
    chk("rst_ofl", bus.Ofl, 0);
    chk("rst_ldb", bus.Ld_B, 0);
    chk("rst_busy", bus.Busy, 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
`ifdef SUBTRACT_EN
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0);
`endif
    do_op(16'h8000, 16'h8000, 1'b0, 1'b1);

    for (int i = 0; i < 12; i++) begin
`ifdef SUBTRACT_EN
      sub = 1'($urandom);
`else
      sub = 1'b0;
`endif
      do_op(W'($urandom), W'($urandom), sub, i[0]);
    end

    // Abort at ADD cycle 7: async clear, no strobe afterwards.
    @(negedge Clk);
    bus.A = 16'hA5A5; bus.B = 16'h5A5A; bus.Run = 1'b1;
    @(posedge Clk); #1;
    bus.Run = 1'b0;
    repeat (7) @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    chk("abort_sum", bus.Sum, 0);
    chk("abort_ofl", bus.Ofl, 0);
    chk("abort_ldb", bus.Ld_B, 0);
    chk("abort_busy", bus.Busy, 0);
    @(negedge Clk);
    Reset = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(posedge Clk); #1;
      if (bus.Ld_B === 1'b1) pulses++;
    end
    chk("abort_no_ldb", pulses, 0);

    // Run already high when reset releases: starts next edge, one strobe over 40 cycles.
    @(negedge Clk);
    Reset = 1'b1; bus.Run = 1'b1; bus.A = W'($urandom); bus.B = W'($urandom);
    @(negedge Clk);
    Reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge Clk); #1;
      if (c == 0) chk("rst_release_start", bus.Busy, 1);
      if (bus.Ld_B === 1'b1) pulses++;
    end
    chk("run_held_one_ldb", pulses, 1);
    chk("run_held_busy", bus.Busy, 1);
    bus.Run = 1'b0;
    @(posedge Clk); #1;
    chk("run_drop_idle", bus.Busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
